sm83_irq_ctrl: RTL and testbench
================================

# sm83_irq_ctrl

Interrupt latch, mask and dispatch controller for the SM83 core. It sits between the peripheral interrupt request lines and the instruction sequencer. It holds the IF and IE registers, the IME flag with the one-instruction EI delay, and fixed-priority selection. It hands the sequencer a dispatch request and a restart vector through a req/ack handshake, and drives the HALT wake line.

## Interface
Parameters:
- NUM_IRQ, 5, number of interrupt sources (1..8); bit 0 has the highest priority.
- VEC_BASE, 8'h40, vector of source 0.
- VEC_STRIDE, 8, vector spacing in bytes.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- nreset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- irq_req  in  NUM_IRQ  peripheral request pulses/levels; each cycle high sets the IF bit.
- if_wr, ie_wr  in  1  register write strobes.
- wdata  in  8  write data (low NUM_IRQ bits used).
- if_rdata, ie_rdata  out  8  register readback.
- ei, di, reti  in  1  one-cycle opcode strobes from the decoder.
- instr_done  in  1  instruction-boundary strobe.
- halt  in  1  core is in HALT.
- dispatch_req  out  1  interrupt dispatch requested.
- dispatch_ack  in  1  sequencer accepts dispatch.
- vec  out  8  restart address; valid while vec_valid.
- vec_valid  out  1  one-cycle vector strobe.
- wake  out  1  pending-and-enabled source exists.
- halt_bug  out  1  see Configuration.

## Operation
- pending = IF & IE. wake = |pending, combinational from registers and independent of IME.
- IF update priority on each edge, highest first:
  - reset
  - irq_req set
  - dispatch clear of the selected bit
  - if_wr
- Consequences of that order: a set on the same cycle as a clear or a write leaves the bit at 1.
- if_rdata = {ones in bits 7..NUM_IRQ, IF}. With the default parameters, IF = 0 reads 8'hE0.
- ie_rdata = {ones in bits 7..NUM_IRQ, IE}. ie_wr takes effect at the next edge.
- IME:
  - di clears both ime and ime_pend.
  - reti sets ime immediately.
  - ei sets ime_pend. ime becomes 1 on the first instr_done edge strictly after the ei edge, then ime_pend clears.
  - ei and di in the same cycle: di wins.
  - ei repeated while ime_pend is set: no change.
- FSM states:
  - IDLE → REQ on an edge with instr_done & ime & |pending. dispatch_req goes to 1.
  - REQ holds dispatch_req until dispatch_ack. di or IE/IF changes in REQ do not withdraw the request.
  - REQ → VEC on the edge with dispatch_ack:
    - ime is cleared and ime_pend is cleared.
    - pending is re-evaluated at this edge. The lowest set bit k is cleared in IF, and vec = VEC_BASE + k·VEC_STRIDE.
    - If pending is now 0, vec = 8'h00 and no IF bit changes.
  - VEC → IDLE after one cycle. vec_valid = 1 only while in VEC.
- dispatch_ack outside REQ is ignored.

## Timing
- Reset values:
  - IF = 0, IE = 0, ime = 0, ime_pend = 0, state IDLE.
  - dispatch_req = 0, vec = 8'h00, vec_valid = 0, wake = 0, halt_bug = 0.
- irq_req to IF bit visible: 1 cycle. irq_req to wake: 1 cycle.
- instr_done edge to dispatch_req high: registered, visible in the following cycle.
- dispatch_ack edge to vec_valid: the next cycle, for exactly one cycle. vec holds its value until the next dispatch.
- Minimum dispatch-to-dispatch spacing: 3 cycles (REQ, VEC, IDLE, REQ).
- nreset low mid-handshake: returns to IDLE with all outputs at reset values at that edge. A pending ack is lost.

## Configuration
- SM83_IRQ_HALT_BUG_EN defined:
  - halt_bug pulses for one cycle on the edge where halt rises while ime = 0 and |pending.
  - The sequencer uses it to suppress the next PC increment.
- Undefined: halt_bug is tied to 0 and the detection logic is not built.

## Test plan
- Reset, then read registers → if_rdata = 8'hE0, ie_rdata = 8'hE0, all outputs 0.
- IE = 8'h05, IME on, pulse irq_req = 5'b00101, then instr_done → dispatch_req; ack → vec = 8'h40, IF = 8'hE4. Second dispatch → vec = 8'h50.
- Pulse ei, then instr_done twice with pending present → no request after the first instr_done, dispatch_req after the second.
- In REQ, write IE = 0, then ack → vec = 8'h00, vec_valid = 1, IF unchanged, ime = 0.
- Same cycle: irq_req[2] = 1 and if_wr with wdata = 0 → IF bit 2 = 1. Same cycle: ei and di → ime stays 0.
- Macro defined: ime = 0, IE = IF = 8'h01, raise halt → halt_bug = 1 for one cycle and wake = 1. Macro undefined → halt_bug stays 0.

Source files
------------

// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl: interrupt latch (IF), enable mask (IE), IME with the EI
// delay, fixed-priority selection and req/ack dispatch to the sequencer.
// Optional feature macro: SM83_IRQ_HALT_BUG_EN builds the HALT-bug detector;
// when undefined, halt_bug is tied low.
module sm83_irq_ctrl #(
  parameter int          NUM_IRQ    = 5,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter int          VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               if_wr,
  input  logic               ie_wr,
  input  logic [7:0]         wdata,
  output logic [7:0]         if_rdata,
  output logic [7:0]         ie_rdata,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               instr_done,
  input  logic               halt,
  output logic               dispatch_req,
  input  logic               dispatch_ack,
  output logic [7:0]         vec,
  output logic               vec_valid,
  output logic               wake,
  output logic               halt_bug
);

  typedef enum logic [1:0] {IDLE, REQ, VEC} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] if_q, ie_q, pending, sel, if_nxt;
  logic               ime, ime_pend, found, take;
  logic [7:0]         sel_idx, vec_q, vec_nxt;
  logic               unused_bits;

  assign pending = if_q & ie_q;
  assign wake    = |pending;
  assign take    = (state == REQ) && dispatch_ack;
  assign vec     = vec_q;

  // Lowest set pending bit wins; also forms the restart vector.
  always_comb begin
    sel     = '0;
    found   = 1'b0;
    sel_idx = 8'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && !found) begin
        found   = 1'b1;
        sel[i]  = 1'b1;
        sel_idx = 8'(i);
      end
    end
    vec_nxt = found ? VEC_BASE + 8'(int'(sel_idx) * VEC_STRIDE) : 8'h00;
  end

  // Next IF: write lowest priority, then dispatch clear, then request set.
  always_comb begin
    if_nxt = if_wr ? wdata[NUM_IRQ-1:0] : if_q;
    if (take) if_nxt = if_nxt & ~sel;
    if_nxt = if_nxt | irq_req;
  end

  // Register readback with unimplemented upper bits reading as one.
  always_comb begin
    if_rdata              = 8'hFF;
    ie_rdata              = 8'hFF;
    if_rdata[NUM_IRQ-1:0] = if_q;
    ie_rdata[NUM_IRQ-1:0] = ie_q;
  end

  // Dispatch FSM next state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    dispatch_req = 1'b0;
    vec_valid    = 1'b0;
    case (state)
      IDLE: if (instr_done && ime && (|pending)) state_nxt = REQ;
      REQ: begin
        dispatch_req = 1'b1;
        if (dispatch_ack) state_nxt = VEC;
      end
      VEC: begin
        vec_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // IF/IE registers and the latched vector.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      if_q  <= '0;
      ie_q  <= '0;
      vec_q <= 8'h00;
    end else begin
      if_q <= if_nxt;
      if (ie_wr) ie_q <= wdata[NUM_IRQ-1:0];
      if (take)  vec_q <= vec_nxt;
    end
  end

  // IME with one-instruction EI delay; di and dispatch both disable.
  always_ff @(posedge clk) begin
    if (!nreset || di || take) begin
      ime      <= 1'b0;
      ime_pend <= 1'b0;
    end else begin
      if (reti) ime <= 1'b1;
      if (ei && !ime_pend) begin
        ime_pend <= 1'b1;
      end else if (ime_pend && instr_done) begin
        ime      <= 1'b1;
        ime_pend <= 1'b0;
      end
    end
  end

`ifdef SM83_IRQ_HALT_BUG_EN
  logic halt_q, halt_bug_q;

  // HALT entered with IME off and an interrupt already pending.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      halt_q     <= 1'b0;
      halt_bug_q <= 1'b0;
    end else begin
      halt_q     <= halt;
      halt_bug_q <= halt && !halt_q && !ime && (|pending);
    end
  end

  assign halt_bug    = halt_bug_q;
  assign unused_bits = ^wdata;
`else
  assign halt_bug    = 1'b0;
  assign unused_bits = ^{wdata, halt};
`endif

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Self-checking bench for sm83_irq_ctrl: directed test-plan sequences followed
// by randomized traffic, all compared against a behavioural model; dispatched
// vectors go through a scoreboard queue checked by an independent monitor.
module tb_sm83_irq_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [4:0] irq_req;
  logic       if_wr, ie_wr, ei, di, reti, instr_done, halt, dispatch_ack;
  logic [7:0] wdata;
  logic [7:0] if_rdata, ie_rdata, vec;
  logic       dispatch_req, vec_valid, wake, halt_bug;

  always #5 clk = ~clk;

  sm83_irq_ctrl dut (
    .clk(clk), .nreset(nreset), .irq_req(irq_req), .if_wr(if_wr), .ie_wr(ie_wr),
    .wdata(wdata), .if_rdata(if_rdata), .ie_rdata(ie_rdata), .ei(ei), .di(di),
    .reti(reti), .instr_done(instr_done), .halt(halt), .dispatch_req(dispatch_req),
    .dispatch_ack(dispatch_ack), .vec(vec), .vec_valid(vec_valid), .wake(wake),
    .halt_bug(halt_bug)
  );

  int total  = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  // Behavioural model: registers, IME, and where the handshake currently is.
  logic [4:0] m_if, m_ie;
  bit         m_ime, m_ime_armed, m_halt_seen, m_hb;
  int         m_phase;    // 0 = no request, 1 = requesting, 2 = vector shown
  logic [7:0] m_vec;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int lowest_bit(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [4:0] pend;
    int         k;
    bit         old_ime;
    int         old_phase;
    logic [4:0] base;
    if (!nreset) begin
      m_if = '0; m_ie = '0; m_ime = 0; m_ime_armed = 0; m_phase = 0;
      m_vec = 8'h00; m_hb = 0; m_halt_seen = 0;
      return;
    end
    pend      = m_if & m_ie;
    old_ime   = m_ime;
    old_phase = m_phase;
    base      = if_wr ? wdata[4:0] : m_if;
    if (old_phase == 1 && dispatch_ack) begin
      k = lowest_bit(pend);
      if (k >= 0) begin
        m_vec = 8'(8'h40 + 8 * k);
        base[k] = 1'b0;
      end else begin
        m_vec = 8'h00;
      end
      exp_q.push_back(m_vec);
    end
    m_if = base | irq_req;
    if (ie_wr) m_ie = wdata[4:0];
    // IME rules
    if (di || (old_phase == 1 && dispatch_ack)) begin
      m_ime = 0; m_ime_armed = 0;
    end else begin
      if (reti) m_ime = 1;
      if (ei && !m_ime_armed) m_ime_armed = 1;
      else if (m_ime_armed && instr_done) begin m_ime = 1; m_ime_armed = 0; end
    end
    // handshake progress
    case (old_phase)
      0: if (instr_done && old_ime && pend != 0) m_phase = 1;
      1: if (dispatch_ack) m_phase = 2;
      default: m_phase = 0;
    endcase
`ifdef SM83_IRQ_HALT_BUG_EN
    m_hb = halt && !m_halt_seen && !old_ime && pend != 0;
`else
    m_hb = 0;
`endif
    m_halt_seen = halt;
  endtask

  task automatic compare_all();
    chk("if_rdata", if_rdata, {3'b111, m_if});
    chk("ie_rdata", ie_rdata, {3'b111, m_ie});
    chk("wake", wake, int'((m_if & m_ie) != 0));
    chk("dispatch_req", dispatch_req, int'(m_phase == 1));
    chk("vec_valid", vec_valid, int'(m_phase == 2));
    chk("vec", vec, m_vec);
    chk("halt_bug", halt_bug, m_hb);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic clr_in();
    irq_req = '0; if_wr = 0; ie_wr = 0; wdata = 8'h00; ei = 0; di = 0;
    reti = 0; instr_done = 0; dispatch_ack = 0;
  endtask

  // Scoreboard monitor: every presented vector must match the oldest expectation.
  always @(negedge clk) begin
    if (vec_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_vec: got %0h, expected no vector", vec);
      end else begin
        chk("sb_vec", vec, exp_q.pop_front());
      end
    end
  end

  initial begin
    clr_in();
    halt = 0;
    nreset = 0;
    step(); step();
    nreset = 1;
    #0;
    // reset state
    chk("rst_if", if_rdata, 8'hE0);
    chk("rst_ie", ie_rdata, 8'hE0);
    chk("rst_outs", {dispatch_req, vec_valid, wake, halt_bug}, 0);
    chk("rst_vec", vec, 8'h00);

    // basic dispatch, two sources
    ie_wr = 1; wdata = 8'h05; step(); clr_in();
    reti = 1; step(); clr_in();
    irq_req = 5'b00101; step(); clr_in();
    chk("if_set", if_rdata, 8'hE5);
    chk("wake_set", wake, 1);
    instr_done = 1; step(); clr_in();
    chk("req_up", dispatch_req, 1);
    dispatch_ack = 1; step(); clr_in();
    chk("vec0", vec, 8'h40);
    chk("vv0", vec_valid, 1);
    chk("if_after0", if_rdata, 8'hE4);
    reti = 1; step(); clr_in();
    instr_done = 1; step(); clr_in();
    dispatch_ack = 1; step(); clr_in();
    chk("vec2", vec, 8'h50);
    chk("if_after2", if_rdata, 8'hE0);

    // EI delay
    irq_req = 5'b00001; step(); clr_in();
    ei = 1; step(); clr_in();
    instr_done = 1; step(); clr_in();
    chk("ei_delay_no_req", dispatch_req, 0);
    instr_done = 1; step(); clr_in();
    chk("ei_delay_req", dispatch_req, 1);
    // request survives IE cleared; ack finds nothing pending
    ie_wr = 1; wdata = 8'h00; step(); clr_in();
    chk("req_held", dispatch_req, 1);
    dispatch_ack = 1; step(); clr_in();
    chk("empty_vec", vec, 8'h00);
    chk("empty_vv", vec_valid, 1);
    chk("empty_if", if_rdata, 8'hE1);
    ie_wr = 1; wdata = 8'h05; step(); clr_in();
    instr_done = 1; step(); clr_in();
    chk("ime_cleared", dispatch_req, 0);

    // set beats write; di beats ei
    irq_req = 5'b00100; if_wr = 1; wdata = 8'h00; step(); clr_in();
    chk("set_over_wr", if_rdata[2], 1);
    ei = 1; di = 1; step(); clr_in();
    repeat (2) begin instr_done = 1; step(); clr_in(); end
    chk("di_wins", dispatch_req, 0);

    // reset mid-handshake drops the ack
    reti = 1; step(); clr_in();
    instr_done = 1; step(); clr_in();
    chk("req_before_rst", dispatch_req, 1);
    dispatch_ack = 1; nreset = 0; step(); clr_in();
    chk("rst_mid_req", dispatch_req, 0);
    chk("rst_mid_if", if_rdata, 8'hE0);
    nreset = 1; step();

    // HALT bug
    if_wr = 1; ie_wr = 1; wdata = 8'h01; step(); clr_in();
    halt = 1; step();
    chk("halt_wake", wake, 1);
`ifdef SM83_IRQ_HALT_BUG_EN
    chk("halt_bug_pulse", halt_bug, 1);
`else
    chk("halt_bug_off", halt_bug, 0);
`endif
    step();
    chk("halt_bug_one", halt_bug, 0);
    halt = 0; step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      clr_in();
      nreset       = ($urandom_range(0, 99) != 0);
      irq_req      = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      if_wr        = ($urandom_range(0, 19) == 0);
      ie_wr        = ($urandom_range(0, 19) == 0);
      wdata        = 8'($urandom);
      ei           = ($urandom_range(0, 9) == 0);
      di           = ($urandom_range(0, 19) == 0);
      reti         = ($urandom_range(0, 14) == 0);
      instr_done   = ($urandom_range(0, 1) == 0);
      dispatch_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      step();
    end
    clr_in();
    nreset = 1;
    step(); step();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
